// File: rtl/xs3_serial_adder.sv
// Digit-serial Excess-3 adder, LS digit first, decimal carry held between beats; 1-cycle latency.
// Output register stalls when out_ready=0, which drops in_ready; pop and push may share an edge.
module xs3_serial_adder #(
  parameter int MAX_DIGITS = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a_xs3,
  input  logic [3:0]       b_xs3,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       sum_xs3,
  output logic             out_last,
  output logic             carry_out,
  output logic             err,
  output logic [CNT_W-1:0] digit_idx
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic             carry;
  logic             sticky;
  logic [CNT_W-1:0] cnt;

  logic       xfer;
  logic       carry_in;
  logic       c_next;
  logic       dig_err;
  logic       ovf;
  logic [4:0] s5;
  logic [3:0] digit;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  // The first digit of an operation never inherits a carry, even if one is left in the register.
  assign carry_in = (state == RUN) && carry;
  assign s5       = {1'b0, a_xs3} + {1'b0, b_xs3} + {4'd0, carry_in};
  assign c_next   = s5[4];
  assign digit    = c_next ? (s5[3:0] + 4'd3) : (s5[3:0] + 4'd13);

  assign dig_err  = (a_xs3 < 4'd3) || (a_xs3 > 4'd12) ||
                    (b_xs3 < 4'd3) || (b_xs3 > 4'd12);
  assign ovf      = !in_last && (cnt == CNT_W'(MAX_DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum_xs3   <= 4'b0000;
      out_last  <= 1'b0;
      carry_out <= 1'b0;
      err       <= 1'b0;
      digit_idx <= '0;
      carry     <= 1'b0;
      sticky    <= 1'b0;
      cnt       <= '0;
      state     <= IDLE;
    end else if (xfer) begin
      out_valid <= 1'b1;
      sum_xs3   <= digit;
      digit_idx <= cnt;
      out_last  <= in_last;
      carry_out <= in_last && c_next;
      err       <= in_last && (sticky || dig_err);
      if (in_last) begin
        carry  <= 1'b0;
        sticky <= 1'b0;
        cnt    <= '0;
        state  <= IDLE;
      end else begin
        // Overlong operands keep accumulating digits at the last index, flagged as an error.
        carry  <= c_next;
        sticky <= sticky || dig_err || ovf;
        cnt    <= ovf ? cnt : cnt + 1'b1;
        state  <= RUN;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xs3_serial_adder.sv
// Bench for xs3_serial_adder: decimal-arithmetic reference model with a per-cycle compare process.
module tb_xs3_serial_adder;
  localparam int MAXD = 4;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    a_xs3 = 4'd0;
  logic [3:0]    b_xs3 = 4'd0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [3:0]    sum_xs3;
  logic          out_last;
  logic          carry_out;
  logic          err;
  logic [CW-1:0] digit_idx;

  xs3_serial_adder #(.MAX_DIGITS(MAXD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_xs3(a_xs3), .b_xs3(b_xs3), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .sum_xs3(sum_xs3),
    .out_last(out_last), .carry_out(carry_out), .err(err), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sum;
    int         idx;
    logic       last;
    logic       cy;
    logic       er;
    logic       sum_dc;
  } beat_t;

  beat_t q[$];    // expected beats, in order
  beat_t got[$];  // beats actually popped from the DUT

  int n_checks = 0;
  int n_errors = 0;

  // Model state: decimal carry, digits seen, error flag, and whether a bad code poisoned the arithmetic.
  int m_carry = 0;
  int m_cnt   = 0;
  bit m_err   = 0;
  bit m_bad   = 0;
  bit rnd_rdy = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_carry = 0;
    m_cnt   = 0;
    m_err   = 0;
    m_bad   = 0;
  endtask

  task automatic model_push(input logic [3:0] a, input logic [3:0] b, input logic last);
    beat_t e;
    int    t;
    bit    bad;
    bit    ovf;
    bad   = (a < 3) || (a > 12) || (b < 3) || (b > 12);
    m_bad = m_bad | bad;
    t     = (int'(a) - 3) + (int'(b) - 3) + m_carry;
    e.sum    = 4'((t % 10) + 3);
    e.sum_dc = m_bad;
    e.cy     = (t >= 10);
    e.idx    = m_cnt;
    e.last   = last;
    ovf      = !last && (m_cnt == MAXD - 1);
    m_err    = m_err | bad | ovf;
    e.er     = m_err;
    q.push_back(e);
    if (last) begin
      m_carry = 0; m_cnt = 0; m_err = 0; m_bad = 0;
    end else begin
      m_carry = (t >= 10) ? 1 : 0;
      if (!ovf) m_cnt++;
    end
  endtask

  // Compare process: checks handshake and popped beats, then records the pending input transfer.
  always @(negedge clk) begin
    beat_t e;
    beat_t g;
    if (!rst) begin
      check("in_ready", int'(in_ready), int'(!out_valid || out_ready));
      check("out_valid", int'(out_valid), int'(q.size() != 0));
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        if (!e.sum_dc) check("sum_xs3", int'(sum_xs3), int'(e.sum));
        check("digit_idx", int'(digit_idx), e.idx);
        check("out_last", int'(out_last), int'(e.last));
        if (e.last) begin
          if (!e.sum_dc) check("carry_out", int'(carry_out), int'(e.cy));
          check("err", int'(err), int'(e.er));
        end else begin
          check("carry_out_nonlast", int'(carry_out), 0);
          check("err_nonlast", int'(err), 0);
        end
        g.sum = sum_xs3; g.idx = int'(digit_idx); g.last = out_last;
        g.cy = carry_out; g.er = err; g.sum_dc = 1'b0;
        got.push_back(g);
      end
      if (in_valid && in_ready) model_push(a_xs3, b_xs3, in_last);
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1 out_ready = ($urandom_range(3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the transfer edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last);
    int n = 0;
    a_xs3 = a; b_xs3 = b; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_got(input string name, input int i, input logic [3:0] s, input int idx,
                         input logic last, input logic cy, input logic er);
    if (i >= got.size()) begin
      check({name, "_present"}, got.size(), i + 1);
    end else begin
      check({name, "_sum"}, int'(got[i].sum), int'(s));
      check({name, "_idx"}, got[i].idx, idx);
      check({name, "_last"}, int'(got[i].last), int'(last));
      if (last) begin
        check({name, "_carry"}, int'(got[i].cy), int'(cy));
        check({name, "_err"}, int'(got[i].er), int'(er));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sum", int'(sum_xs3), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_carry_out", int'(carry_out), 0);
    check("rst_err", int'(err), 0);
    check("rst_idx", int'(digit_idx), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(1);

    // 27 + 48 = 75
    got.delete();
    send(4'b1010, 4'b1011, 1'b0);
    send(4'b0101, 4'b0111, 1'b1);
    idle(3);
    chk_got("d27p48_0", 0, 4'b1000, 0, 1'b0, 1'b0, 1'b0);
    chk_got("d27p48_1", 1, 4'b1010, 1, 1'b1, 1'b0, 1'b0);

    // 99 + 01 = 100
    got.delete();
    send(4'b1100, 4'b0100, 1'b0);
    send(4'b1100, 4'b0011, 1'b1);
    idle(3);
    chk_got("d99p01_0", 0, 4'b0011, 0, 1'b0, 1'b0, 1'b0);
    chk_got("d99p01_1", 1, 4'b0011, 1, 1'b1, 1'b1, 1'b0);

    // Invalid code, then a clean operation with the sticky error gone
    got.delete();
    send(4'b1111, 4'b0011, 1'b1);
    send(4'b0011, 4'b0011, 1'b1);
    idle(3);
    check("badcode_err", got.size() > 0 ? int'(got[0].er) : -1, 1);
    check("badcode_last", got.size() > 0 ? int'(got[0].last) : -1, 1);
    chk_got("after_bad", 1, 4'b0011, 0, 1'b1, 1'b0, 1'b0);

    // Length overflow: five digits into a four-digit adder
    got.delete();
    for (int i = 0; i < 5; i++) send(4'b0100, 4'b0100, (i == 4));
    idle(3);
    chk_got("ovf_0", 0, 4'b0101, 0, 1'b0, 1'b0, 1'b0);
    chk_got("ovf_2", 2, 4'b0101, 2, 1'b0, 1'b0, 1'b0);
    chk_got("ovf_3", 3, 4'b0101, 3, 1'b0, 1'b0, 1'b0);
    chk_got("ovf_4", 4, 4'b0101, 3, 1'b1, 1'b0, 1'b1);

    // Backpressure on the first sum digit of 27 + 48
    got.delete();
    send(4'b1010, 4'b1011, 1'b0);
    out_ready = 1'b0;
    a_xs3 = 4'b0101; b_xs3 = 4'b0111; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_sum_stable", int'(sum_xs3), 4'b1000);
      check("bp_out_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_sum", int'(sum_xs3), 4'b1010);
    check("bp_next_last", int'(out_last), 1);
    idle(3);
    check("bp_count", got.size(), 2);
    chk_got("bp_0", 0, 4'b1000, 0, 1'b0, 1'b0, 1'b0);
    chk_got("bp_1", 1, 4'b1010, 1, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of 99 + 01, then 0 + 0
    got.delete();
    send(4'b1100, 4'b0100, 1'b0);
    #2 rst = 1'b1;
    model_clear();
    #1;
    check("mrst_out_valid", int'(out_valid), 0);
    check("mrst_sum", int'(sum_xs3), 0);
    check("mrst_idx", int'(digit_idx), 0);
    @(posedge clk); #1 rst = 1'b0;
    got.delete();
    send(4'b0011, 4'b0011, 1'b1);
    idle(3);
    check("mrst_count", got.size(), 1);
    chk_got("mrst_0p0", 0, 4'b0011, 0, 1'b1, 1'b0, 1'b0);

    // Randomized operations with random gaps and random output stalls
    rnd_rdy = 1;
    for (int op = 0; op < 300; op++) begin
      int len;
      len = $urandom_range(5, 1);
      for (int d = 0; d < len; d++) begin
        logic [3:0] a;
        logic [3:0] b;
        a = 4'($urandom_range(12, 3));
        b = 4'($urandom_range(12, 3));
        if ($urandom_range(31) == 0) a = 4'($urandom_range(2, 0));
        if ($urandom_range(31) == 0) b = 4'($urandom_range(15, 13));
        send(a, b, (d == len - 1));
        if ($urandom_range(3) == 0) idle($urandom_range(2, 1));
      end
    end
    rnd_rdy = 0;
    @(posedge clk); #2 out_ready = 1'b1;
    idle(4);
    check("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
